// File: rtl/riscv_fetch.sv
// Instruction-fetch stage: owns the PC, addresses the synchronous program RAM and
// presents the fetched instruction (the RAM output register) with its PC to decode.
module riscv_fetch #(
  parameter int unsigned     XLen     = 32,
  parameter int unsigned     ILen     = 32,
  parameter logic [XLen-1:0] BootAddr = 32'h0000_0000,
  parameter logic [ILen-1:0] Nop      = 32'h0000_0013
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLen-1:0] redirect_pc_i,
  output logic [XLen-1:0] pmem_addr_o,
  input  logic [ILen-1:0] pmem_rdata_i,
  output logic            id_valid_o,
  output logic [XLen-1:0] id_pc_o,
  output logic [XLen-1:0] id_pc_plus4_o,
  output logic [ILen-1:0] id_instr_o,
  output logic            id_misaligned_o
);

  localparam logic [XLen-1:0] Four = XLen'(4);

  logic [XLen-1:0] pc_q, pc_d;
  logic [XLen-1:0] id_pc_q, id_pc_d;
  logic            id_valid_q, id_valid_d;
  logic            id_mis_q, id_mis_d;
  logic [XLen-1:0] target;

  assign target = {redirect_pc_i[XLen-1:2], 2'b00};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q       <= BootAddr;
      id_pc_q    <= BootAddr;
      id_valid_q <= 1'b0;
      id_mis_q   <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
      id_mis_q   <= id_mis_d;
    end
  end

  // Redirect beats stall; a stall freezes everything so the RAM re-reads the ID word.
  always_comb begin
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    id_mis_d   = id_mis_q;
    if (redirect_i) begin
      pc_d       = target + Four;
      id_pc_d    = target;
      id_valid_d = 1'b1;
      id_mis_d   = |redirect_pc_i[1:0];
    end else if (!stall_i) begin
      pc_d       = pc_q + Four;
      id_pc_d    = pc_q;
      id_valid_d = 1'b1;
      id_mis_d   = 1'b0;
    end
  end

  always_comb begin
    if (rst_i) begin
      pmem_addr_o = BootAddr;
    end else if (redirect_i) begin
      pmem_addr_o = target;
    end else if (stall_i) begin
      pmem_addr_o = id_pc_q;
    end else begin
      pmem_addr_o = pc_q;
    end
  end

  // The ID slot is squashed in the redirect cycle: it holds a wrong-path instruction.
  always_comb begin
    id_valid_o      = id_valid_q & ~redirect_i;
    id_instr_o      = id_valid_o ? pmem_rdata_i : Nop;
    id_pc_o         = id_pc_q;
    id_pc_plus4_o   = id_pc_q + Four;
    id_misaligned_o = id_mis_q & id_valid_o;
  end

endmodule

// File: doc/riscv_fetch.md
# riscv_fetch

Instruction-fetch (IF) stage of the pipelined RISC-V core: owns the program counter, drives the program-memory address, and presents the fetched instruction with its PC to the decode (ID) stage. It sits directly upstream of decode and directly in front of the synchronous program RAM (one-cycle read latency, word-indexed by address bits [AddrWidth-1:2]). It supports pipeline stalls and control-flow redirects from the execute stage, and provides a single-cycle wrong-path squash.

## Interface
- XLen, 32, data/address width in bits
- ILen, 32, instruction width in bits
- BootAddr, 32'h0000_0000, PC after reset; must be word-aligned
- Nop, 32'h0000_0013, instruction presented when ID is invalid (addi x0,x0,0)

- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- stall_i  in  1  hold IF and ID contents (hazard unit)
- redirect_i  in  1  taken branch/jump resolved in EX; one-cycle pulse
- redirect_pc_i  in  XLen  redirect target
- pmem_addr_o  out  XLen  byte address to program RAM (combinational)
- pmem_rdata_i  in  ILen  RAM read data, valid one cycle after address
- id_valid_o  out  1  ID slot holds a real instruction
- id_pc_o  out  XLen  PC of the ID instruction
- id_pc_plus4_o  out  XLen  id_pc_o + 4, modulo 2^XLen
- id_instr_o  out  ILen  instruction for decode
- id_misaligned_o  out  1  ID instruction came from a misaligned redirect target

## Operation
- State: pc_q (next fetch address), id_pc_q, id_valid_q, id_mis_q.
- The RAM output register acts as the IF/ID instruction register; id_pc_q/id_valid_q track it.
- pmem_addr_o priority: redirect_i -> {redirect_pc_i[XLen-1:2],2'b00}; else stall_i -> id_pc_q (re-read, keeps RAM output stable); else pc_q.
- Normal advance (no stall, no redirect): id_pc_q <= pc_q, id_valid_q <= 1, id_mis_q <= 0, pc_q <= pc_q + 4.
- Redirect (wins over stall): with T = aligned target, id_pc_q <= T, id_valid_q <= 1, id_mis_q <= |redirect_pc_i[1:0], pc_q <= T + 4.
- Stall without redirect: all registers hold; the address re-reads id_pc_q.
- id_valid_o = id_valid_q & ~redirect_i. This squashes the wrong-path ID instruction in the redirect cycle.
- id_instr_o = id_valid_o ? pmem_rdata_i : Nop.
- id_pc_o = id_pc_q. id_misaligned_o = id_mis_q & id_valid_o.
- All PC arithmetic is unsigned XLen-bit with wrap: 0xFFFF_FFFC + 4 = 0.

## Timing
- Reset values, held while rst_i=1: pc_q=BootAddr, id_pc_q=BootAddr, id_valid_q=0, id_mis_q=0.
- Outputs during reset: pmem_addr_o=BootAddr, id_valid_o=0, id_instr_o=Nop, id_pc_o=BootAddr, id_pc_plus4_o=BootAddr+4, id_misaligned_o=0.
- Reset asserted mid-operation clears state immediately, regardless of stall or redirect, with no clock edge required.
- First edge after reset release fetches BootAddr. From cycle 1 onward: id_valid_o=1, id_pc_o=BootAddr, id_instr_o=mem[BootAddr].
- Throughput: 1 instruction/cycle when not stalled.
- Fetch-to-ID latency: 1 cycle.
- Redirect penalty: the ID instruction in the redirect cycle is squashed. The target appears in ID on the next cycle, so there is 1 bubble seen by decode.
- A stall spanning any number of cycles leaves id_pc_o/id_instr_o unchanged. The instruction is neither lost nor duplicated.
- Simultaneous stall_i and redirect_i: the redirect is taken and the stall is ignored for IF.
- Consecutive redirects on back-to-back cycles: each is taken, and the last target wins.

## Test plan
- Reset with BootAddr=0 and mem[0..3]=0x00500093, 0x00a00113, 0x002081b3, 0x00000013; release reset -> cycles 1-4 show id_pc_o=0,4,8,C with matching instructions, pmem_addr_o leading by one word, and id_valid_o=1 throughout.
- Stall_i high for 3 cycles while id_pc_o=4 -> id_pc_o=4 and id_instr_o=0x00a00113 held for 3 cycles; after release the next is 8 with no skip or duplicate.
- Redirect_i pulse to 0x40 while id_pc_o=8 -> id_valid_o=0 and id_instr_o=0x00000013 that cycle; next cycle id_pc_o=0x40 and id_instr_o=mem[0x40]; then 0x44.
- Redirect_i and stall_i together to 0x80 -> next cycle id_pc_o=0x80 and id_valid_o=1.
- Redirect to 0x42 -> id_pc_o=0x40 and id_misaligned_o=1 for exactly that instruction; 0 for 0x44.
- Redirect to 0xFFFFFFFC -> id_pc_plus4_o=0, and the following id_pc_o=0. Asserting rst_i mid-stream -> outputs return to reset values within the same cycle.
